serial_adder_nand: RTL and testbench
====================================

Name: serial_adder_nand

Overview:
Bit-serial, LSB-first adder that consumes the sum/carry outputs of a NAND-built half-adder pair.
- Adds two WIDTH-bit operands over WIDTH clock cycles, one bit per cycle, using a single full-adder cell and a carry flip-flop.
- Sits directly downstream of the combinational half-adder stage and turns it into a multi-bit sequential datapath.
- Uses a start/busy/done handshake toward the controlling logic.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; sampled on the accepting edge only
- b  input  WIDTH  operand B; sampled on the accepting edge only
- busy  output  1  high while an addition is in progress (RUN state)
- done  output  1  one-cycle pulse; sum/carry_out are valid from this cycle on
- sum  output  WIDTH  registered result, held until the next completion
- carry_out  output  1  registered final carry, held until the next completion

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - state = IDLE; busy = 0; done = 0; sum = 0; carry_out = 0
  - operand shift registers, partial-sum shift register, carry flop and bit counter all cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start = 1: load a and b into shift registers, clear carry flop, clear counter, go to RUN.
  - start = 0: stay in IDLE.
- RUN, each edge:
  - Full-add operand LSBs with the carry flop: sum_bit = a0 ^ b0 ^ c; c_next = a0&b0 | c&(a0^b0).
  - Shift both operands right by 1.
  - Shift sum_bit into the MSB of the partial-sum register, which shifts right.
  - Update carry flop; increment counter.
- RUN exit:
  - On the edge where counter == WIDTH-1, copy the completed partial-sum into sum and c_next into carry_out, then go to DONE.
- DONE:
  - done = 1 for exactly this one cycle.
  - Next edge returns to IDLE unconditionally.
- Latency and timing:
  - Accepting edge E0; bit edges E1..EW.
  - busy high from after E0 until after EW.
  - done high from after EW until after E(W+1).
  - Earliest next accept is E(W+1) if start is high there; it must be ignored, since the block is in DONE. Accept resumes at E(W+2).
- start while in RUN or DONE is ignored; no queuing.
- a and b changing after E0 has no effect on the result in progress.
- sum and carry_out keep the previous result throughout RUN; they change only on the completion edge.
- Overflow: the true result is WIDTH+1 bits; sum holds the low WIDTH bits and carry_out the MSB; nothing saturates.
- Reset asserted mid-RUN or in DONE:
  - Immediate abort to reset values; no done pulse.
  - Previous sum and carry_out are cleared to 0.
- Counter width: $clog2(WIDTH).

Decomposition:
- Shared package or header: state encoding constants IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
- Sub-module: full_adder_nand, a 1-bit full adder built from two NAND-only half-adder cells plus a NAND-built OR for the carry.
  - Instantiated once as the serial datapath cell.
  - Gate-level only, no behavioural operators.
- Top level holds the FSM, shift registers, counter and result registers.

Test Plan:
- Reset and zero add: rst_n low then high; start with a = 8'h00, b = 8'h00.
  - Expect busy for 8 cycles, then done pulse of 1 cycle, sum = 8'h00, carry_out = 0.
- Full carry ripple: a = 8'hFF, b = 8'h01.
  - Expect sum = 8'h00, carry_out = 1.
  - done asserted exactly 8 edges after the accepting edge.
- No-carry pattern then double max: a = 8'hA5, b = 8'h5A gives sum = 8'hFF, carry_out = 0.
  - Next transaction a = 8'hFF, b = 8'hFF gives sum = 8'hFE, carry_out = 1.
  - During the second run, sum must still read 8'hFF.
- Ignored start and operand change: hold start = 1 continuously.
  - Change a and b to 8'h33 mid-run; result must match the original operands (8'h12 + 8'h34 gives sum = 8'h46).
  - Next accept occurs 2 edges after done, not 1.
- Reset mid-operation: start 8'hF0 + 8'h0F, assert rst_n low after 4 bit edges.
  - Expect busy = 0, done never pulses, sum = 8'h00, carry_out = 0.
  - A fresh 8'h01 + 8'h01 afterwards gives sum = 8'h02.
- Random regression: 500 random a/b pairs with WIDTH = 8 and WIDTH = 16.
  - Check {carry_out, sum} == a + b and check done/busy timing on every transaction.

Source files
------------

// File: rtl/serial_adder_nand_pkg.sv
// serial_adder_nand_pkg: shared state encoding for the bit-serial adder
package serial_adder_nand_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/full_adder_nand.sv
// full_adder_nand: 1-bit full adder from two NAND-only half-adders and a NAND-built OR
module half_adder_nand (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_cn
);
    logic w_n1, w_n2;
    nand g0 (o_cn, i_a, i_b);
    nand g1 (w_n1, i_a, o_cn);
    nand g2 (w_n2, i_b, o_cn);
    nand g3 (o_s, w_n1, w_n2);
endmodule

module full_adder_nand (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_s1, w_cn1, w_cn2;
    half_adder_nand u_ha0 (.i_a(i_a),  .i_b(i_b), .o_s(w_s1), .o_cn(w_cn1));
    half_adder_nand u_ha1 (.i_a(w_s1), .i_b(i_c), .o_s(o_s),  .o_cn(w_cn2));
    // inverted half-adder carries feed a NAND, which acts as their OR
    nand g_or (o_c, w_cn1, w_cn2);
endmodule

// File: rtl/serial_adder_nand.sv
// serial_adder_nand: LSB-first bit-serial adder, one full-adder cell plus carry flop,
// with a start/busy/done handshake
module serial_adder_nand
    import serial_adder_nand_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_psum, r_sum, w_psum;
    logic [CW-1:0]    r_cnt;
    logic             r_c, r_cout, w_s, w_c, w_last;

    full_adder_nand u_fa (.i_a(r_a[0]), .i_b(r_b[0]), .i_c(r_c), .o_s(w_s), .o_c(w_c));

    assign w_last    = r_cnt == CW'(WIDTH - 1);
    assign w_psum    = {w_s, r_psum[WIDTH-1:1]};
    assign busy      = r_state == RUN;
    assign done      = r_state == DONE;
    assign sum       = r_sum;
    assign carry_out = r_cout;

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
                 (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_a    <= a;
                r_b    <= b;
                r_psum <= '0;
                r_c    <= 1'b0;
                r_cnt  <= '0;
            end else if (r_state == RUN) begin
                r_a    <= r_a >> 1;
                r_b    <= r_b >> 1;
                r_psum <= w_psum;
                r_c    <= w_c;
                r_cnt  <= r_cnt + CW'(1);
                // results move only on the final bit edge so they hold through the run
                if (w_last) begin
                    r_sum  <= w_psum;
                    r_cout <= w_c;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_nand.sv
// tb_serial_adder_nand: table-driven + scoreboard bench for 8- and 16-bit serial adders
module tb_serial_adder_nand;
    logic        clk = 0, rst_n = 0;
    logic        start8 = 0, start16 = 0;
    logic [7:0]  a8 = 0, b8 = 0, sum8;
    logic [15:0] a16 = 0, b16 = 0, sum16;
    logic        busy8, done8, cout8, busy16, done16, cout16;
    logic [8:0]  q8[$];
    logic [16:0] q16[$];
    logic [8:0]  last8 = 0;
    logic [16:0] last16 = 0;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] r;
    } vec_t;
    vec_t tbl[6];

    serial_adder_nand #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8)
    );
    serial_adder_nand #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .carry_out(cout16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) chk("done8 unexpected", 1, 0);
            else begin
                last8 = q8.pop_front();
                chk("result8", {cout8, sum8}, last8);
            end
        end
        if (done16) begin
            if (q16.size() == 0) chk("done16 unexpected", 1, 0);
            else begin
                last16 = q16.pop_front();
                chk("result16", {cout16, sum16}, last16);
            end
        end
    end

    task automatic do8(input logic [7:0] x, input logic [7:0] y, input logic [8:0] r);
        @(negedge clk);
        a8 = x; b8 = y; start8 = 1;
        @(posedge clk);
        q8.push_back(r);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin start8 = 0; a8 = x ^ 8'h5A; b8 = ~y; end
            chk("busy8", busy8, 1);
            chk("done8 early", done8, 0);
            chk("hold8", {cout8, sum8}, last8);
        end
        @(negedge clk);
        chk("done8 pulse", done8, 1);
        chk("busy8 at done", busy8, 0);
        @(negedge clk);
        chk("done8 one cycle", done8, 0);
    endtask

    task automatic do16(input logic [15:0] x, input logic [15:0] y, input logic [16:0] r);
        @(negedge clk);
        a16 = x; b16 = y; start16 = 1;
        @(posedge clk);
        q16.push_back(r);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) begin start16 = 0; a16 = ~x; b16 = ~y; end
            chk("busy16", busy16, 1);
            chk("done16 early", done16, 0);
            chk("hold16", {cout16, sum16}, last16);
        end
        @(negedge clk);
        chk("done16 pulse", done16, 1);
        chk("busy16 at done", busy16, 0);
        @(negedge clk);
        chk("done16 one cycle", done16, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{8'h00, 8'h00, 9'h000};
        tbl[1] = '{8'hFF, 8'h01, 9'h100};
        tbl[2] = '{8'hA5, 8'h5A, 9'h0FF};
        tbl[3] = '{8'hFF, 8'hFF, 9'h1FE};
        tbl[4] = '{8'h80, 8'h80, 9'h100};
        tbl[5] = '{8'h7F, 8'h01, 9'h080};

        repeat (3) @(negedge clk);
        chk("reset busy8", busy8, 0);
        chk("reset done8", done8, 0);
        chk("reset result8", {cout8, sum8}, 0);
        chk("reset result16", {cout16, sum16}, 0);
        rst_n = 1;

        for (int i = 0; i < 6; i++) do8(tbl[i].a, tbl[i].b, tbl[i].r);

        // start held high with operands changing mid-run
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; start8 = 1;
        @(posedge clk);
        q8.push_back(9'h046);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 3) begin a8 = 8'h33; b8 = 8'h33; end
            chk("busy8 held start", busy8, 1);
        end
        @(negedge clk);
        chk("done8 held start", done8, 1);
        @(negedge clk);
        chk("ignored start in DONE", busy8, 0);
        q8.push_back(9'h066);
        @(negedge clk);
        chk("re-accept after done", busy8, 1);
        start8 = 0;
        repeat (8) @(negedge clk);
        chk("done8 second held run", done8, 1);
        @(negedge clk);

        // reset mid-run
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'h0F; start8 = 1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start8 = 0;
        rst_n = 0;
        #1;
        chk("abort busy8", busy8, 0);
        chk("abort done8", done8, 0);
        chk("abort result8", {cout8, sum8}, 0);
        last8 = 0;
        last16 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no done after abort", done8, 0);
        end
        do8(8'h01, 8'h01, 9'h002);

        for (int i = 0; i < 500; i++) begin
            logic [7:0] x, y;
            x = 8'($urandom);
            y = 8'($urandom);
            do8(x, y, {1'b0, x} + {1'b0, y});
        end
        do16(16'hFFFF, 16'h0001, 17'h10000);
        for (int i = 0; i < 500; i++) begin
            logic [15:0] x, y;
            x = 16'($urandom);
            y = 16'($urandom);
            do16(x, y, {1'b0, x} + {1'b0, y});
        end

        repeat (2) @(negedge clk);
        chk("scoreboard8 drained", q8.size(), 0);
        chk("scoreboard16 drained", q16.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
